mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data bus; the responder end of the store/load interface the core drives (addr, 3-bit one-hot write_enable, data_in, data_out). The core writes bytes to a DATA register; the block queues them in a small FIFO and serialises them 8N1, LSB first, on one output pin. Its read data is ORed into the bus read mux alongside memory.

Parameters:
BASE_ADDR, 32'h0000_1000, register window base; must be 16-byte aligned.
DEFAULT_DIV, 16'd104, reset value of DIVISOR (clock cycles per bit).
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
addr  in  32  byte address from the core ALU result.
write_enable  in  3  3'b100 byte store, 3'b010 half store, 3'b001 word store, 3'b000 read/idle.
data_in  in  32  store data.
data_out  out  32  registered read data; 0 when not selected.
tx  out  1  serial output, idle high.

Behaviour:
- Decode: hit = (addr[31:4] == BASE_ADDR[31:4]). Offset addr[3:2]: 0 = DATA, 1 = STATUS, 2 = DIVISOR, 3 = reserved (reads 0, writes ignored).
- Writes act in every cycle where write_enable != 0 and hit; the core holds write_enable for exactly one cycle per store.
- DATA write, any size: enqueue data_in[7:0].
- STATUS write: writing 1 to bit 3 clears overflow; other bits read-only.
- DIVISOR write: byte store updates [7:0]; half or word store updates [15:0].
- Reads: when write_enable == 0 and hit, data_out <= selected register at the next edge (1-cycle latency); otherwise data_out <= 0.
- Register read values:
  - DATA reads 0.
  - STATUS = {23'b0, count[4:0] in [8:4], overflow[3], empty[2], full[1], busy[0]}. busy = FSM not IDLE.
  - DIVISOR = {16'b0, div}.
- FIFO: write pointer, read pointer, count 0..FIFO_DEPTH.
  - Enqueue when full: byte dropped, overflow set (sticky).
  - Enqueue and pop in the same cycle while full: both happen, no overflow, count unchanged.
  - A pop never sees an entry enqueued in the same cycle.
- FSM states: IDLE, START, DATA, STOP. Registers: bit counter 0..7, cycle counter, latched divisor, shift register.
  - IDLE: tx = 1. If FIFO non-empty: pop into shift register, latch div (0 is treated as 1), go to START. tx goes low on that same edge.
  - START: tx = 0 for div cycles, then go to DATA.
  - DATA: tx = shift[0] for div cycles per bit, shift right, 8 bits.
  - STOP: tx = 1 for div cycles. Then go to START (popping the FIFO) if it is non-empty, otherwise go to IDLE. There is no idle gap between queued frames.
- Timing: a frame lasts exactly 10*div cycles. The first tx fall occurs at edge W+1, where W is the edge that sampled the DATA store into an empty FIFO with FSM IDLE.
- DIVISOR writes mid-frame do not affect the current frame; they take effect at the next frame start.
- Reset, including mid-frame, at the next edge: tx = 1, FSM IDLE, FIFO emptied, overflow = 0, div = DEFAULT_DIV, data_out = 0. A partial frame is abandoned.

Test Plan:
- Reset, then read STATUS and DIVISOR -> data_out = 32'h0000_0004 (empty) and 32'h0000_0068 respectively, tx = 1.
- Word-store DIVISOR = 4, byte-store DATA = 8'h55 -> tx low at W+1. Then for 4 cycles each: 0, 1,0,1,0,1,0,1,0, 1; tx high after 40 cycles; busy 1 throughout the frame, then 0.
- div = 2, five back-to-back DATA stores (0x01..0x05), FIFO_DEPTH = 4 -> first byte popped immediately, remaining four fit, no overflow. Then:
  - A sixth store while full sets STATUS bit 3.
  - All five frames are emitted contiguously (100 cycles), with no gap between stop and start bits.
- With overflow set, word-store STATUS = 32'h8 -> overflow reads 0 while other bits are unchanged. Also: byte-store DIVISOR = 8'h10 when div = 16'h0104 -> div reads 16'h0110.
- Assert rst for 1 cycle mid-DATA-bit -> tx = 1 next cycle, STATUS = 0x4, no further edges on tx. div = 0 written then DATA sent -> frame uses 1 cycle per bit (10 cycles).
- Reads at BASE_ADDR + 32'h10 and at offset 0xC -> data_out = 0. A store to BASE_ADDR + 32'h10 -> no enqueue, count unchanged.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIVISOR registers, a small
// TX FIFO, and a serialiser FSM that sends queued bytes back to back.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter logic [15:0] DEFAULT_DIV = 16'd104,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [2:0]  write_enable,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [CNT_W-1:0]   count;
   logic               overflow;
   logic [15:0]        div;
   logic [15:0]        div_lat;
   logic [15:0]        cyc_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift;

   logic               hit_c;
   logic [1:0]         off_c;
   logic               wr_c;
   logic               push_c;
   logic               push_ok_c;
   logic               pop_c;
   logic               full_c;
   logic               empty_c;
   logic               cyc_end_c;
   logic               busy_c;
   logic [31:0]        rd_c;
   logic               unused_c;

   // Address decode, FIFO handshake and read mux
   always_comb begin
      hit_c     = (addr[31:4] == BASE_ADDR[31:4]);
      off_c     = addr[3:2];
      wr_c      = hit_c && (write_enable != 3'b000);
      push_c    = wr_c && (off_c == 2'd0);
      full_c    = (count == CNT_W'(FIFO_DEPTH));
      empty_c   = (count == CNT_W'(0));
      cyc_end_c = (cyc_cnt == (div_lat - 16'd1));
      busy_c    = (state != IDLE);
      pop_c     = !empty_c && ((state == IDLE) || ((state == STOP) && cyc_end_c));
      push_ok_c = push_c && (!full_c || pop_c);
      rd_c      = 32'd0;
      case (off_c)
         2'd1:    rd_c = {23'd0, 5'(count), overflow, empty_c, full_c, busy_c};
         2'd2:    rd_c = {16'd0, div};
         default: rd_c = 32'd0;
      endcase
      unused_c  = ^{addr[1:0], data_in[31:16]};
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok_c) fifo_mem[wptr] <= data_in[7:0];
   end

   // Registers, FIFO pointers and serialiser FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         div      <= DEFAULT_DIV;
         div_lat  <= 16'd1;
         cyc_cnt  <= 16'd0;
         bit_cnt  <= 3'd0;
         shift    <= 8'd0;
         tx       <= 1'b1;
         data_out <= 32'd0;
      end else begin
         data_out <= (hit_c && (write_enable == 3'b000)) ? rd_c : 32'd0;

         if (push_c && full_c && !pop_c) begin
            overflow <= 1'b1;
         end else if (wr_c && (off_c == 2'd1) && data_in[3]) begin
            overflow <= 1'b0;
         end

         if (wr_c && (off_c == 2'd2)) begin
            if (write_enable == 3'b100) begin
               div[7:0] <= data_in[7:0];
            end else if ((write_enable == 3'b010) || (write_enable == 3'b001)) begin
               div <= data_in[15:0];
            end
         end

         if (push_ok_c) wptr <= wptr + PTR_W'(1);
         if (pop_c)     rptr <= rptr + PTR_W'(1);
         case ({push_ok_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // A pop always starts a frame; the divisor is frozen for its duration
         if (pop_c) begin
            state   <= START;
            shift   <= fifo_mem[rptr];
            div_lat <= (div == 16'd0) ? 16'd1 : div;
            cyc_cnt <= 16'd0;
            bit_cnt <= 3'd0;
            tx      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  tx <= 1'b1;
               end
               START: begin
                  if (cyc_end_c) begin
                     state   <= DATA;
                     cyc_cnt <= 16'd0;
                     tx      <= shift[0];
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               DATA: begin
                  if (cyc_end_c) begin
                     cyc_cnt <= 16'd0;
                     if (bit_cnt == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= shift >> 1;
                        tx      <= shift[1];
                     end
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               STOP: begin
                  if (cyc_end_c) begin
                     state   <= IDLE;
                     cyc_cnt <= 16'd0;
                     tx      <= 1'b1;
                  end else begin
                     cyc_cnt <= cyc_cnt + 16'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected tx waveform and read data are
// queued as stimulus is issued and compared as the DUT produces them.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [2:0]  write_enable;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        tx;

   int          tests;
   int          fails;
   logic        tx_q [$];
   logic [31:0] rd_q [$];
   logic        idle_chk;

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .DEFAULT_DIV (16'd104),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .write_enable (write_enable),
      .data_in      (data_in),
      .data_out     (data_out),
      .tx           (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; tx is compared against the queued waveform, else against idle
   task automatic tick();
      logic e;
      @(posedge clk);
      #1;
      if (tx_q.size() != 0) begin
         e = tx_q.pop_front();
         chk("tx", {31'd0, tx}, {31'd0, e});
      end else if (idle_chk) begin
         chk("tx_idle", {31'd0, tx}, 32'd1);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [2:0] we, input logic [31:0] d);
      addr         = a;
      write_enable = we;
      data_in      = d;
      tick();
      write_enable = 3'b000;
      addr         = 32'd0;
      data_in      = 32'd0;
   endtask

   task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      addr         = a;
      write_enable = 3'b000;
      tick();
      chk(tag, data_out, rd_q.pop_front());
      addr = 32'd0;
   endtask

   task automatic push_frame(input logic [7:0] b, input int d);
      logic v;
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      v = 1'b0;
         else if (i == 9) v = 1'b1;
         else             v = b[i-1];
         for (int c = 0; c < d; c++) tx_q.push_back(v);
      end
   endtask

   // Byte store to DATA; a frame from idle starts one cycle after the store edge
   task automatic send(input logic [7:0] b, input int d, input bit from_idle);
      if (from_idle) tx_q.push_back(1'b1);
      push_frame(b, d);
      store(BASE, 3'b100, {24'd0, b});
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (tx_q.size() != 0 && guard < 5000) begin
         tick();
         guard++;
      end
      chk("drain_bound", 32'(tx_q.size()), 32'd0);
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      idle_chk     = 1'b0;
      rst          = 1'b1;
      addr         = 32'd0;
      write_enable = 3'b000;
      data_in      = 32'd0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_dout", data_out, 32'd0);
      idle_chk = 1'b1;
      read("status_rst", BASE + 32'h4, 32'h0000_0004);
      read("div_rst",    BASE + 32'h8, 32'h0000_0068);

      // Single frame, div 4, 0x55, with busy tracked through the frame
      store(BASE + 32'h8, 3'b001, 32'd4);
      send(8'h55, 4, 1'b1);
      tx_q.push_back(1'b1);
      addr = BASE + 32'h4;
      for (int j = 1; j <= 41; j++) begin
         tick();
         if (j >= 2) chk("busy_frame", {31'd0, data_out[0]}, 32'd1);
      end
      read("status_after_frame", BASE + 32'h4, 32'h0000_0004);

      // Five back-to-back bytes at div 2, then a sixth that overflows
      store(BASE + 32'h8, 3'b001, 32'd2);
      send(8'h01, 2, 1'b1);
      send(8'h02, 2, 1'b0);
      send(8'h03, 2, 1'b0);
      send(8'h04, 2, 1'b0);
      send(8'h05, 2, 1'b0);
      store(BASE, 3'b100, 32'h0000_00AA);
      read("status_full_ovf", BASE + 32'h4, 32'h0000_004B);
      drain();
      repeat (4) tick();
      read("status_ovf_idle", BASE + 32'h4, 32'h0000_000C);

      // Overflow clear and divisor partial writes
      store(BASE + 32'h4, 3'b001, 32'h0000_0008);
      read("status_ovf_clr", BASE + 32'h4, 32'h0000_0004);
      store(BASE + 32'h8, 3'b001, 32'h0000_0104);
      read("div_word", BASE + 32'h8, 32'h0000_0104);
      store(BASE + 32'h8, 3'b100, 32'hFFFF_FF10);
      read("div_byte", BASE + 32'h8, 32'h0000_0110);
      store(BASE + 32'h8, 3'b010, 32'hABCD_0004);
      read("div_half", BASE + 32'h8, 32'h0000_0004);

      // Reset mid data bit abandons the frame
      send(8'h55, 4, 1'b1);
      repeat (9) tick();
      tx_q.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_dout", data_out, 32'd0);
      read("status_midrst", BASE + 32'h4, 32'h0000_0004);
      read("div_midrst",    BASE + 32'h8, 32'h0000_0068);
      repeat (20) tick();

      // Divisor 0 behaves as 1 cycle per bit
      store(BASE + 32'h8, 3'b001, 32'd0);
      send(8'hA3, 1, 1'b1);
      drain();
      repeat (3) tick();

      // Out-of-window and reserved accesses
      read("rd_win_plus16", BASE + 32'h10, 32'd0);
      read("rd_reserved",   BASE + 32'hC,  32'd0);
      read("rd_data_reg",   BASE,          32'd0);
      store(BASE + 32'h10, 3'b100, 32'h0000_0077);
      read("status_no_enq", BASE + 32'h4, 32'h0000_0004);
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
